// File: rtl/cp0_exception_ctrl.sv
// ============================================================================
// cp0_exception_ctrl : commit-stage exception/interrupt/ERET CP0 sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_exception_ctrl #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_in_delay,
  input  logic [6:0]       ex_flags,
  input  logic [WIDTH-1:0] ex_badaddr,
  input  logic             ex_eret,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] cp0_we,
  output logic [WIDTH-1:0] cp0_epc,
  output logic [WIDTH-1:0] cp0_badaddr,
  output logic             cp0_exl,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_bd,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRAP      = 3'd1,
    S_ERET      = 3'd2,
    S_REDIR_EXC = 3'd3,
    S_REDIR_RET = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] badaddr_q, badaddr_d;
  logic             bd_q, bd_d;
  logic             adr_q, adr_d;

  logic             int_pending;
  logic             trap;
  logic [4:0]       cause_code;
  logic [WIDTH-1:0] cause_addr;
  logic             cause_adr;

  assign int_pending = status_in[0] & ~status_in[1] & (|(status_in[15:10] & hw_int));
  assign trap        = ex_valid & ((|ex_flags) | int_pending);

  // Priority encode causes; address-error causes also carry a BadVAddr value.
  always_comb begin
    cause_code = 5'd0;
    cause_addr = '0;
    cause_adr  = 1'b0;
    if (int_pending) begin
      cause_code = 5'd0;
    end else if (ex_flags[0]) begin
      cause_code = 5'd4;
      cause_addr = ex_pc;
      cause_adr  = 1'b1;
    end else if (ex_flags[1]) begin
      cause_code = 5'd10;
    end else if (ex_flags[2]) begin
      cause_code = 5'd12;
    end else if (ex_flags[3]) begin
      cause_code = 5'd8;
    end else if (ex_flags[4]) begin
      cause_code = 5'd9;
    end else if (ex_flags[5]) begin
      cause_code = 5'd4;
      cause_addr = ex_badaddr;
      cause_adr  = 1'b1;
    end else if (ex_flags[6]) begin
      cause_code = 5'd5;
      cause_addr = ex_badaddr;
      cause_adr  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    badaddr_d = badaddr_q;
    bd_d      = bd_q;
    adr_d     = adr_q;
    unique case (state_q)
      S_IDLE: begin
        if (trap) begin
          state_d   = S_TRAP;
          exccode_d = cause_code;
          epc_d     = ex_in_delay ? (ex_pc - WIDTH'(4)) : ex_pc;
          bd_d      = ex_in_delay;
          badaddr_d = cause_addr;
          adr_d     = cause_adr;
        end else if (ex_valid & ex_eret) begin
          state_d = S_ERET;
          epc_d   = epc_in;
        end
      end
      S_TRAP:      state_d = S_REDIR_EXC;
      S_ERET:      state_d = S_REDIR_RET;
      S_REDIR_EXC: state_d = S_IDLE;
      S_REDIR_RET: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      exccode_q <= '0;
      epc_q     <= '0;
      badaddr_q <= '0;
      bd_q      <= 1'b0;
      adr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      badaddr_q <= badaddr_d;
      bd_q      <= bd_d;
      adr_q     <= adr_d;
    end
  end

  always_comb begin
    cp0_we         = '0;
    cp0_epc        = '0;
    cp0_badaddr    = '0;
    cp0_exl        = 1'b0;
    cp0_exccode    = 5'd0;
    cp0_bd         = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      S_TRAP: begin
        stall       = 1'b1;
        flush       = 1'b1;
        cp0_we[12]  = 1'b1;
        cp0_we[13]  = 1'b1;
        cp0_we[14]  = 1'b1;
        cp0_we[8]   = adr_q;
        cp0_exl     = 1'b1;
        cp0_exccode = exccode_q;
        cp0_bd      = bd_q;
        cp0_epc     = epc_q;
        cp0_badaddr = adr_q ? badaddr_q : '0;
      end
      S_ERET: begin
        stall      = 1'b1;
        flush      = 1'b1;
        cp0_we[12] = 1'b1;
      end
      S_REDIR_EXC: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
      end
      S_REDIR_RET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = epc_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exception_ctrl.sv
// ============================================================================
// tb_cp0_exception_ctrl : directed + random bench against a cycle-queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_in_delay;
  logic [6:0]  ex_flags;
  logic [31:0] ex_badaddr;
  logic        ex_eret;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic [31:0] epc_in;
  logic [31:0] cp0_we, cp0_epc, cp0_badaddr, redirect_pc;
  logic        cp0_exl, cp0_bd, stall, flush, redirect_valid;
  logic [4:0]  cp0_exccode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_exception_ctrl #(.WIDTH(32), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_in_delay(ex_in_delay), .ex_flags(ex_flags), .ex_badaddr(ex_badaddr),
    .ex_eret(ex_eret), .hw_int(hw_int), .status_in(status_in), .epc_in(epc_in),
    .cp0_we(cp0_we), .cp0_epc(cp0_epc), .cp0_badaddr(cp0_badaddr),
    .cp0_exl(cp0_exl), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] we, epc, badaddr, rpc;
    logic        exl, bd, stall, flush, rv, idle;
    logic [4:0]  code;
  } exp_t;

  exp_t q[$];

  function automatic exp_t blank();
    exp_t e;
    e.we = 0; e.epc = 0; e.badaddr = 0; e.rpc = 0;
    e.exl = 0; e.bd = 0; e.stall = 0; e.flush = 0; e.rv = 0; e.idle = 0;
    e.code = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check current outputs, drive next inputs, advance model.
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                     input logic dly, input logic [6:0] fl, input logic [31:0] ba,
                     input logic er, input logic [5:0] hw, input logic [31:0] st,
                     input logic [31:0] ep);
    exp_t cur, t, rd;
    int   k;
    logic ip;
    int   codes[7] = '{4, 10, 12, 8, 9, 4, 5};
    @(negedge clk);
    if (q.size() > 0) cur = q.pop_front();
    else begin cur = blank(); cur.idle = 1; end
    chk("we", cp0_we, cur.we);
    chk("epc", cp0_epc, cur.epc);
    chk("badaddr", cp0_badaddr, cur.badaddr);
    chk("exl", 32'(cp0_exl), 32'(cur.exl));
    chk("exccode", 32'(cp0_exccode), 32'(cur.code));
    chk("bd", 32'(cp0_bd), 32'(cur.bd));
    chk("stall", 32'(stall), 32'(cur.stall));
    chk("flush", 32'(flush), 32'(cur.flush));
    chk("redirect_valid", 32'(redirect_valid), 32'(cur.rv));
    chk("redirect_pc", redirect_pc, cur.rpc);
    rst = r; ex_valid = v; ex_pc = pc; ex_in_delay = dly; ex_flags = fl;
    ex_badaddr = ba; ex_eret = er; hw_int = hw; status_in = st; epc_in = ep;
    if (r) begin
      q.delete();
    end else if (cur.idle && v) begin
      ip = st[0] && !st[1] && ((st[15:10] & hw) != 6'd0);
      t = blank(); rd = blank();
      rd.flush = 1; rd.rv = 1;
      if (ip || fl != 7'd0) begin
        t.stall = 1; t.flush = 1; t.exl = 1; t.we = 32'h0000_7000;
        t.epc = dly ? pc - 32'd4 : pc;
        t.bd = dly;
        if (!ip) begin
          k = 0;
          while (!fl[k]) k++;
          t.code = 5'(codes[k]);
          if (k == 0 || k >= 5) begin
            t.we = t.we | 32'h0000_0100;
            t.badaddr = (k == 0) ? pc : ba;
          end
        end
        rd.rpc = 32'hBFC00380;
        q.push_back(t); q.push_back(rd);
      end else if (er) begin
        t.stall = 1; t.flush = 1; t.we = 32'h0000_1000;
        rd.rpc = ep;
        q.push_back(t); q.push_back(rd);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_pc = 0; ex_in_delay = 0; ex_flags = 0;
    ex_badaddr = 0; ex_eret = 0; hw_int = 0; status_in = 0; epc_in = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Sys
    cyc(0, 1, 32'h8000_1000, 0, 7'b0001000, 0, 0, 0, 0, 0);
    idle(3);
    // delay-slot Ov+RI
    cyc(0, 1, 32'h8000_2004, 1, 7'b0000110, 0, 0, 0, 0, 0);
    idle(3);
    // data AdES
    cyc(0, 1, 32'h8000_2100, 0, 7'b1000000, 32'h8000_0003, 0, 0, 0, 0);
    idle(3);
    // fetch AdEL in delay slot
    cyc(0, 1, 32'h8000_0002, 1, 7'b0100001, 32'h1234_5678, 0, 0, 0, 0);
    idle(3);
    // interrupt beats ERET, then EXL masks it
    cyc(0, 1, 32'h8000_4000, 0, 0, 0, 1, 6'b000001, 32'h0000_0401, 32'h8000_3000);
    idle(3);
    cyc(0, 1, 32'h8000_4000, 0, 0, 0, 1, 6'b000001, 32'h0000_0403, 32'h8000_3000);
    idle(3);
    // held ERET: re-accepted only after the redirect cycle; EPC change ignored mid-sequence
    cyc(0, 1, 32'h8000_5000, 0, 0, 0, 1, 0, 0, 32'h8000_3000);
    cyc(0, 1, 32'h8000_5000, 0, 0, 0, 1, 0, 0, 32'h8000_3abc);
    cyc(0, 1, 32'h8000_5000, 0, 0, 0, 1, 0, 0, 32'h8000_3abc);
    cyc(0, 1, 32'h8000_5000, 0, 0, 0, 1, 0, 0, 32'h8000_7000);
    idle(4);
    // reset during TRAP aborts write and redirect
    cyc(0, 1, 32'h8000_6000, 0, 7'b0010000, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // random
    for (int i = 0; i < 400; i++) begin
      logic [6:0] fl;
      fl = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          $urandom & 32'hFFFF_FFFC | 32'($urandom_range(0, 3) == 0 ? 2 : 0),
          1'($urandom), fl, $urandom,
          ($urandom_range(0, 2) == 0), 6'($urandom),
          $urandom & 32'h0000_FC03, $urandom);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
